// File: rtl/dma_hold_page_ctrl_if.sv
// -----------------------------------------------------------------------------
// dma_hold_page_ctrl_if
//
// Purpose : bundles the bus-hold handshake, the DMA address/data taps, the CPU
//           page-register write port and the assembled system address between
//           the 8237 DMA core, the host CPU and dma_hold_page_ctrl.
//
// Signals :
//   HRQ        hold request from the DMA core
//   HLDA       hold acknowledge to the DMA core
//   CPU_BUSY   CPU bus cycle in progress
//   CPU_LOCK_n CPU locked sequence, active low
//   CPU_FLOAT  CPU must float its bus
//   AEN        DMA address enable
//   ADSTB      upper address strobe (DB carries A[15:8])
//   DACK[3:0]  channel acknowledge, active high
//   DB[7:0]    DMA data bus
//   A_LO[7:0]  DMA address A[7:0]
//   PG_WE      page register write strobe
//   PG_ADDR    page register index
//   PG_DATA    page value, becomes SA[19:16]
//   SA[19:0]   system address
//   SA_VALID   SA driven by DMA
//
// Modports:
//   slave  - the controller side (dma_hold_page_ctrl)
//   master - the environment side (DMA core + CPU, or a testbench)
// -----------------------------------------------------------------------------
interface dma_hold_page_ctrl_if;
    logic        HRQ;
    logic        HLDA;
    logic        CPU_BUSY;
    logic        CPU_LOCK_n;
    logic        CPU_FLOAT;
    logic        AEN;
    logic        ADSTB;
    logic [3:0]  DACK;
    logic [7:0]  DB;
    logic [7:0]  A_LO;
    logic        PG_WE;
    logic [1:0]  PG_ADDR;
    logic [3:0]  PG_DATA;
    logic [19:0] SA;
    logic        SA_VALID;

    modport slave (
        input  HRQ, CPU_BUSY, CPU_LOCK_n, AEN, ADSTB, DACK, DB, A_LO,
               PG_WE, PG_ADDR, PG_DATA,
        output HLDA, CPU_FLOAT, SA, SA_VALID
    );

    modport master (
        output HRQ, CPU_BUSY, CPU_LOCK_n, AEN, ADSTB, DACK, DB, A_LO,
               PG_WE, PG_ADDR, PG_DATA,
        input  HLDA, CPU_FLOAT, SA, SA_VALID
    );
endinterface

// File: rtl/dma_hold_page_ctrl.sv
// -----------------------------------------------------------------------------
// dma_hold_page_ctrl
//
// Purpose : system-side companion to an 8237 DMA core.
//           * Arbitrates the bus hold: HRQ from the DMA core is only answered
//             with HLDA once the CPU is neither busy nor locked, with one
//             CPU_FLOAT turnaround cycle before HLDA and one after it.
//           * Builds the 20-bit system address from a 4x4-bit page register
//             file (SA[19:16]), the ADSTB-latched upper byte (SA[15:8]) and
//             the live low address byte (SA[7:0]).
//
// Ports   :
//   CLK    system clock, rising edge
//   RESET  asynchronous, active-high reset
//   bus    dma_hold_page_ctrl_if.slave (see interface file for signal list)
// -----------------------------------------------------------------------------
module dma_hold_page_ctrl (
    input  logic                     CLK,
    input  logic                     RESET,
    dma_hold_page_ctrl_if.slave      bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_CPU = 3'd1,
        FLOAT    = 3'd2,
        GRANT    = 3'd3,
        RELEASE  = 3'd4
    } hold_state_t;

    hold_state_t state;
    logic        hlda;
    logic        cpu_float;
    logic [7:0]  hi;
    logic [3:0]  page [4];
    logic [1:0]  ch;
    logic        page_wr_ok;
    logic        sa_valid;

    // -------------------------------------------------------------------------
    // Hold FSM. HLDA and CPU_FLOAT are registered alongside the state so they
    // change on the same edge as the state they belong to.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            hlda      <= 1'b0;
            cpu_float <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hlda      <= 1'b0;
                    cpu_float <= 1'b0;
                    if (bus.HRQ) begin
                        state <= WAIT_CPU;
                    end
                end

                WAIT_CPU: begin
                    if (!bus.HRQ) begin
                        // Request withdrawn before the CPU let go of the bus.
                        state <= IDLE;
                    end else if (!bus.CPU_BUSY && bus.CPU_LOCK_n) begin
                        state     <= FLOAT;
                        cpu_float <= 1'b1;
                    end
                end

                FLOAT: begin
                    // Turnaround cycle: the CPU is floated but the DMA core is
                    // not yet granted. A late HRQ drop is deliberately ignored
                    // here and handled from GRANT.
                    state <= GRANT;
                    hlda  <= 1'b1;
                end

                GRANT: begin
                    if (!bus.HRQ) begin
                        state <= RELEASE;
                        hlda  <= 1'b0;
                    end
                end

                RELEASE: begin
                    // CPU_FLOAT trails HLDA by one cycle on the way out.
                    state     <= IDLE;
                    cpu_float <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    hlda      <= 1'b0;
                    cpu_float <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Upper address byte latch: DB carries A[15:8] while ADSTB is high.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hi <= 8'h00;
        end else if (bus.ADSTB) begin
            hi <= bus.DB;
        end
    end

    // -------------------------------------------------------------------------
    // Page register file. The CPU may only reprogram pages while it still owns
    // the bus; the decision uses the current state, so a write in the cycle
    // that moves WAIT_CPU to FLOAT still lands.
    // -------------------------------------------------------------------------
    assign page_wr_ok = (state == IDLE) || (state == WAIT_CPU);

    // NOTE: the page file is only four small registers and SA must read zero
    // after reset, so it is reset like any other flop rather than left as an
    // uninitialised memory.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) begin
                page[i] <= 4'h0;
            end
        end else if (bus.PG_WE && page_wr_ok) begin
            page[bus.PG_ADDR] <= bus.PG_DATA;
        end
    end

    // -------------------------------------------------------------------------
    // Channel select: lowest-index asserted DACK wins; none asserted -> ch 0.
    // -------------------------------------------------------------------------
    // NOTE: ch gets a default before the priority chain so every path assigns
    // it and no latch is inferred.
    always_comb begin
        ch = 2'd0;
        if (bus.DACK[0]) begin
            ch = 2'd0;
        end else if (bus.DACK[1]) begin
            ch = 2'd1;
        end else if (bus.DACK[2]) begin
            ch = 2'd2;
        end else if (bus.DACK[3]) begin
            ch = 2'd3;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. SA is forced to zero whenever the DMA does not own the address
    // bus, so downstream decode never sees a stale DMA address.
    // -------------------------------------------------------------------------
    assign sa_valid      = bus.AEN & hlda;
    assign bus.SA_VALID  = sa_valid;
    assign bus.SA        = sa_valid ? {page[ch], hi, bus.A_LO} : 20'h00000;
    assign bus.HLDA      = hlda;
    assign bus.CPU_FLOAT = cpu_float;

endmodule

// File: tb/tb_dma_hold_page_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dma_hold_page_ctrl
//
// Directed testbench for dma_hold_page_ctrl. Inputs are driven and outputs
// sampled 1 time unit after each rising edge; expected values are written by
// hand from the intended cycle behaviour.
// -----------------------------------------------------------------------------
module tb_dma_hold_page_ctrl;

    logic CLK = 1'b0;
    logic RESET;

    int checks = 0;
    int errors = 0;

    dma_hold_page_ctrl_if bus ();

    dma_hold_page_ctrl dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic page_write(input logic [1:0] addr, input logic [3:0] data);
        bus.PG_WE   = 1'b1;
        bus.PG_ADDR = addr;
        bus.PG_DATA = data;
        tick();
        bus.PG_WE   = 1'b0;
    endtask

    task automatic check_hold(input string tag, input logic float_exp, input logic hlda_exp);
        check({tag, "_float"}, {31'd0, bus.CPU_FLOAT}, {31'd0, float_exp});
        check({tag, "_hlda"},  {31'd0, bus.HLDA},      {31'd0, hlda_exp});
    endtask

    initial begin
        RESET          = 1'b1;
        bus.HRQ        = 1'b0;
        bus.CPU_BUSY   = 1'b0;
        bus.CPU_LOCK_n = 1'b1;
        bus.AEN        = 1'b0;
        bus.ADSTB      = 1'b0;
        bus.DACK       = 4'b0000;
        bus.DB         = 8'h00;
        bus.A_LO       = 8'h00;
        bus.PG_WE      = 1'b0;
        bus.PG_ADDR    = 2'd0;
        bus.PG_DATA    = 4'h0;
        tick(2);
        RESET = 1'b0;
        tick();

        // Reset state
        check_hold("rst", 1'b0, 1'b0);
        check("rst_sa",    {12'd0, bus.SA},       32'h0);
        check("rst_valid", {31'd0, bus.SA_VALID}, 32'h0);

        // Program pages in IDLE
        page_write(2'd1, 4'h1);
        page_write(2'd2, 4'hA);
        page_write(2'd3, 4'hF);

        // Basic grant: 3 edges to HLDA, CPU_FLOAT one edge earlier
        bus.HRQ = 1'b1;
        tick(); check_hold("g1", 1'b0, 1'b0);
        tick(); check_hold("g2", 1'b1, 1'b0);
        tick(); check_hold("g3", 1'b1, 1'b1);

        // Address assembly
        bus.DACK  = 4'b0100;
        bus.DB    = 8'h5C;
        bus.ADSTB = 1'b1;
        tick();
        bus.ADSTB = 1'b0;
        bus.DB    = 8'h99;
        bus.A_LO  = 8'h33;
        bus.AEN   = 1'b1;
        #1;
        check("addr_sa",    {12'd0, bus.SA},       32'hA5C33);
        check("addr_valid", {31'd0, bus.SA_VALID}, 32'h1);
        bus.AEN = 1'b0;
        #1;
        check("aen0_sa",    {12'd0, bus.SA},       32'h0);
        check("aen0_valid", {31'd0, bus.SA_VALID}, 32'h0);

        // Page write during GRANT is dropped
        page_write(2'd2, 4'h3);
        bus.AEN = 1'b1;
        #1;
        check("prot_sa", {12'd0, bus.SA}, 32'hA5C33);

        // DACK priority and no-DACK default
        bus.DACK = 4'b1010; #1;
        check("prio_1010", {28'd0, bus.SA[19:16]}, 32'h1);
        bus.DACK = 4'b1000; #1;
        check("prio_1000", {28'd0, bus.SA[19:16]}, 32'hF);
        bus.DACK = 4'b0000; #1;
        check("prio_none", {12'd0, bus.SA}, 32'h05C33);

        // HI updates one edge after ADSTB
        bus.DACK  = 4'b0100;
        bus.DB    = 8'hE7;
        bus.ADSTB = 1'b1;
        #1;
        check("hi_before", {12'd0, bus.SA}, 32'hA5C33);
        tick();
        bus.ADSTB = 1'b0;
        check("hi_after", {12'd0, bus.SA}, 32'hAE733);

        // Release: HLDA falls after 1 edge, CPU_FLOAT after 2
        bus.HRQ = 1'b0;
        tick(); check_hold("r1", 1'b1, 1'b0);
        check("r1_valid", {31'd0, bus.SA_VALID}, 32'h0);
        tick(); check_hold("r2", 1'b0, 1'b0);
        bus.AEN = 1'b0;

        // Same page write in IDLE lands
        page_write(2'd2, 4'h3);

        // CPU blocking: busy 5 cycles, then locked 2 cycles
        bus.HRQ      = 1'b1;
        bus.CPU_BUSY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); check_hold($sformatf("busy%0d", i), 1'b0, 1'b0);
        end
        bus.CPU_BUSY   = 1'b0;
        bus.CPU_LOCK_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(); check_hold($sformatf("lock%0d", i), 1'b0, 1'b0);
        end
        bus.CPU_LOCK_n = 1'b1;
        tick(); check_hold("blk_f", 1'b1, 1'b0);
        tick(); check_hold("blk_g", 1'b1, 1'b1);

        // IDLE write of page 2 is now visible
        bus.AEN  = 1'b1;
        bus.DACK = 4'b0100;
        #1;
        check("page_idle_wr", {12'd0, bus.SA}, 32'h3E733);

        // Reset mid-GRANT: immediate, asynchronous
        #2;
        RESET = 1'b1;
        #1;
        check_hold("mid_rst", 1'b0, 1'b0);
        check("mid_rst_sa",    {12'd0, bus.SA},       32'h0);
        check("mid_rst_valid", {31'd0, bus.SA_VALID}, 32'h0);
        RESET = 1'b0;

        // HRQ still high: FSM restarts from IDLE with full latency
        tick(); check_hold("post_rst1", 1'b0, 1'b0);
        tick(); check_hold("post_rst2", 1'b1, 1'b0);
        tick(); check_hold("post_rst3", 1'b1, 1'b1);
        check("post_rst_sa", {12'd0, bus.SA}, 32'h00033);
        bus.AEN = 1'b0;
        bus.HRQ = 1'b0;
        tick(2);

        // HRQ withdrawn in WAIT_CPU: no grant
        bus.HRQ      = 1'b1;
        bus.CPU_BUSY = 1'b1;
        tick(2);
        bus.HRQ = 1'b0;
        tick();
        bus.CPU_BUSY = 1'b0;
        tick(); check_hold("wd1", 1'b0, 1'b0);
        tick(); check_hold("wd2", 1'b0, 1'b0);

        // HRQ dropped in FLOAT: GRANT still entered for one cycle
        bus.HRQ = 1'b1;
        tick(2); check_hold("fl_f", 1'b1, 1'b0);
        bus.HRQ = 1'b0;
        tick(); check_hold("fl_g", 1'b1, 1'b1);
        tick(); check_hold("fl_r", 1'b1, 1'b0);
        tick(); check_hold("fl_i", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_hold_page_ctrl.md
# dma_hold_page_ctrl

System-side companion to the 8237 DMA controller core. It arbitrates the bus hold handshake between the controller's HRQ/HLDA pins and the host CPU, and assembles the 20-bit system address from three parts: a 4×4-bit channel page register file, the address-strobe (ADSTB) latched upper address byte, and the live low address byte. It sits directly downstream of the DMA core's HRQ, ADSTB, AEN, DACK and address/data outputs, and upstream of the DMA core's HLDA input.

## Interface
Parameters:
- none

Ports:
- CLK  in  1  system clock; all state updates on its rising edge
- RESET  in  1  asynchronous, active-high reset
- HRQ  in  1  hold request from the DMA core
- HLDA  out  1  hold acknowledge to the DMA core
- CPU_BUSY  in  1  CPU bus cycle in progress
- CPU_LOCK_n  in  1  CPU locked sequence; active low
- CPU_FLOAT  out  1  CPU must float its bus
- AEN  in  1  DMA address enable
- ADSTB  in  1  upper address strobe
- DACK  in  4  channel acknowledge, active high
- DB  in  8  DMA data bus carrying A[15:8] during ADSTB
- A_LO  in  8  DMA address A[7:0] (AH and AL combined)
- PG_WE  in  1  CPU page register write strobe
- PG_ADDR  in  2  page register index
- PG_DATA  in  4  page value, becomes SA[19:16]
- SA  out  20  system address
- SA_VALID  out  1  SA driven by DMA

## Operation
- Hold FSM states: IDLE, WAIT_CPU, FLOAT, GRANT, RELEASE.
- IDLE: HLDA=0, CPU_FLOAT=0. If HRQ=1, go to WAIT_CPU.
- WAIT_CPU: if HRQ=0, go to IDLE (request withdrawn). Else if CPU_BUSY=0 and CPU_LOCK_n=1, go to FLOAT.
- FLOAT: CPU_FLOAT=1, HLDA=0. Next state is always GRANT. This gives one turnaround cycle.
- GRANT: CPU_FLOAT=1, HLDA=1. If HRQ=0, go to RELEASE.
- RELEASE: HLDA=0, CPU_FLOAT=1. Next state is always IDLE, and CPU_FLOAT drops there.
- HRQ dropping in FLOAT is ignored. GRANT is still entered and exits on the next cycle.
- Upper byte latch HI[7:0]: loaded from DB on every clock where ADSTB=1. It holds when ADSTB=0.
- Page file PAGE[0..3] (4 bits each): written with PG_DATA at PG_ADDR when PG_WE=1 and the FSM is in IDLE or WAIT_CPU. Writes in FLOAT, GRANT or RELEASE are dropped.
- Channel select: the lowest-index set bit of DACK. If DACK=0, channel 0 is used.
- SA_VALID = AEN & HLDA. This is combinational from the registered HLDA.
- SA = {PAGE[ch], HI, A_LO} when SA_VALID=1, otherwise 20'h00000. SA is combinational.
- Reset forces the FSM to IDLE, HLDA=0, CPU_FLOAT=0, HI=8'h00 and all PAGE=4'h0, so SA=0 and SA_VALID=0. Reset takes effect immediately, even mid-GRANT. The bus is not held through reset.

## Timing
- HRQ is sampled on the clock edge, with no internal synchronizer. HRQ must be synchronous to CLK.
- Latency from HRQ rise to HLDA rise, with the CPU idle: 3 edges (IDLE→WAIT_CPU→FLOAT→GRANT). HLDA is high after the third edge.
- Each cycle with CPU_BUSY=1 or CPU_LOCK_n=0 in WAIT_CPU adds one cycle.
- HRQ fall to HLDA fall: 1 edge (GRANT→RELEASE).
- CPU_FLOAT falls 2 edges after HRQ falls.
- CPU_FLOAT leads HLDA by 1 cycle on entry and trails it by 1 cycle on exit.
- HI updates 1 edge after a clock with ADSTB=1. If ADSTB=1 coincides with an A_LO change, SA reflects the new HI one cycle later.
- A page write is visible on SA from the next cycle.
- A page write during WAIT_CPU→FLOAT completes, because the write is evaluated in WAIT_CPU.

## Test plan
- Reset then idle: assert RESET mid-GRANT → HLDA=0, CPU_FLOAT=0, SA=20'h00000 and SA_VALID=0 immediately; FSM in IDLE after release.
- Basic grant: CPU_BUSY=0, raise HRQ at edge n → CPU_FLOAT=1 after n+2, HLDA=1 after n+3. Drop HRQ → HLDA=0 after 1 edge, CPU_FLOAT=0 after 2 edges.
- CPU blocking: HRQ=1 with CPU_BUSY=1 for 5 cycles, then CPU_LOCK_n=0 for 2 more → no CPU_FLOAT until both are clear; HLDA rises 2 edges after clearing. HRQ withdrawn in WAIT_CPU → return to IDLE, no grant.
- Address assembly: write PAGE[2]=4'hA, grant, DACK=4'b0100, ADSTB pulse with DB=8'h5C, A_LO=8'h33, AEN=1 → SA=20'hA5C33, SA_VALID=1. AEN=0 → SA=0, SA_VALID=0.
- Page write protection: PG_WE with PG_ADDR=2, PG_DATA=4'h3 during GRANT → PAGE[2] stays 4'hA. The same write in IDLE → 4'h3.
- DACK priority: DACK=4'b1010 with PAGE[1]=4'h1 and PAGE[3]=4'hF → SA[19:16]=4'h1.
